// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle controller: FSM states,
// opcode classes, ALU operation codes and opcode prefixes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  // CLS_NOP doubles as "unknown opcode" and as the reset value of the latched class
  typedef enum logic [3:0] {
    CLS_NOP  = 4'd0,
    CLS_B    = 4'd1,
    CLS_CBZ  = 4'd2,
    CLS_CBNZ = 4'd3,
    CLS_ADDI = 4'd4,
    CLS_SUBI = 4'd5,
    CLS_AND  = 4'd6,
    CLS_ADD  = 4'd7,
    CLS_ORR  = 4'd8,
    CLS_SUB  = 4'd9,
    CLS_STUR = 4'd10,
    CLS_LDUR = 4'd11
  } op_class_t;

  localparam logic [3:0] ALUOP_AND  = 4'b0000;
  localparam logic [3:0] ALUOP_ORR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD  = 4'b0010;
  localparam logic [3:0] ALUOP_SUB  = 4'b0110;
  localparam logic [3:0] ALUOP_CBZ  = 4'b0111;
  localparam logic [3:0] ALUOP_B    = 4'b1000;
  localparam logic [3:0] ALUOP_CBNZ = 4'b1001;

  localparam logic [5:0]  PFX_B    = 6'b000101;
  localparam logic [7:0]  PFX_CBZ  = 8'b10110100;
  localparam logic [7:0]  PFX_CBNZ = 8'b10110101;
  localparam logic [9:0]  PFX_ADDI = 10'b1001000100;
  localparam logic [9:0]  PFX_SUBI = 10'b1101000100;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;

  function automatic logic [3:0] alu_code(input op_class_t cls);
    case (cls)
      CLS_AND:                               alu_code = ALUOP_AND;
      CLS_ORR:                               alu_code = ALUOP_ORR;
      CLS_ADD, CLS_ADDI, CLS_LDUR, CLS_STUR: alu_code = ALUOP_ADD;
      CLS_SUB, CLS_SUBI:                     alu_code = ALUOP_SUB;
      CLS_CBZ:                               alu_code = ALUOP_CBZ;
      CLS_B:                                 alu_code = ALUOP_B;
      CLS_CBNZ:                              alu_code = ALUOP_CBNZ;
      default:                               alu_code = ALUOP_AND;
    endcase
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: top 11 bits of opCode -> opcode class,
// shorter prefixes taking priority over full-width matches.
module opcode_decoder
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 11
) (
  input  logic [OPCODE_W-1:0] opCode,
  output op_class_t           op_class
);

  logic [10:0] top_s;

  assign top_s = opCode[OPCODE_W-1 -: 11];

  // Prefix-priority class decode
  always_comb begin
    op_class = CLS_NOP;
    if (top_s[10:5] == PFX_B) begin
      op_class = CLS_B;
    end else if (top_s[10:3] == PFX_CBZ) begin
      op_class = CLS_CBZ;
    end else if (top_s[10:3] == PFX_CBNZ) begin
      op_class = CLS_CBNZ;
    end else if (top_s[10:1] == PFX_ADDI) begin
      op_class = CLS_ADDI;
    end else if (top_s[10:1] == PFX_SUBI) begin
      op_class = CLS_SUBI;
    end else begin
      case (top_s)
        OPC_AND:  op_class = CLS_AND;
        OPC_ADD:  op_class = CLS_ADD;
        OPC_ORR:  op_class = CLS_ORR;
        OPC_SUB:  op_class = CLS_SUB;
        OPC_STUR: op_class = CLS_STUR;
        OPC_LDUR: op_class = CLS_LDUR;
        default:  op_class = CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle datapath controller with retired-instruction counter.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes instead of executing them as NOPs.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int ALUOP_W  = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                memReady,
  input  logic                aluZero,
  output logic                pcWrite,
  output logic                irWrite,
  output logic                reg2Loc,
  output logic                branch,
  output logic                memRead,
  output logic                memWrite,
  output logic                memToReg,
  output logic                aluSrc,
  output logic                regWrite,
  output logic [ALUOP_W-1:0]  aluOp,
  output logic                retire,
  output logic [CNT_W-1:0]    retireCount,
  output logic                illegal
);

  state_t          state_r;
  op_class_t       class_r;
  op_class_t       dec_class_s;
  logic [CNT_W-1:0] count_r;
  state_t          after_retire_s;

  opcode_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
    .opCode   (opCode),
    .op_class (dec_class_s)
  );

  assign after_retire_s = run ? ST_FETCH : ST_IDLE;
  assign retireCount    = count_r;

  // Sequencing FSM, latched opcode class and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      class_r <= CLS_NOP;
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (retire) begin
        count_r <= count_r + CNT_W'(1'b1);
      end
      case (state_r)
        ST_IDLE:  state_r <= run ? ST_FETCH : ST_IDLE;
        ST_FETCH: state_r <= memReady ? ST_DECODE : ST_FETCH;
        ST_DECODE: begin
          class_r <= dec_class_s;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_r <= (dec_class_s == CLS_NOP) ? ST_TRAP : ST_EXEC;
`else
          state_r <= ST_EXEC;
`endif
        end
        ST_EXEC: begin
          if (class_r == CLS_LDUR || class_r == CLS_STUR) begin
            state_r <= ST_MEM;
          end else if (retire) begin
            state_r <= after_retire_s;
          end else begin
            state_r <= ST_WB;
          end
        end
        ST_MEM: begin
          if (!memReady) begin
            state_r <= ST_MEM;
          end else if (class_r == CLS_STUR) begin
            state_r <= after_retire_s;
          end else begin
            state_r <= ST_WB;
          end
        end
        ST_WB:   state_r <= after_retire_s;
        ST_TRAP: state_r <= ST_TRAP;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Control outputs decoded from the current state and latched class
  always_comb begin
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    reg2Loc  = 1'b0;
    branch   = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    memToReg = 1'b0;
    aluSrc   = 1'b0;
    regWrite = 1'b0;
    aluOp    = {ALUOP_W{1'b0}};
    retire   = 1'b0;
    illegal  = 1'b0;
    case (state_r)
      ST_FETCH: begin
        memRead = 1'b1;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
        end else begin
          irWrite = 1'b0;
          pcWrite = 1'b0;
        end
      end
      ST_EXEC: begin
        aluOp   = ALUOP_W'(alu_code(class_r));
        aluSrc  = class_r inside {CLS_ADDI, CLS_SUBI, CLS_LDUR, CLS_STUR};
        reg2Loc = class_r inside {CLS_STUR, CLS_CBZ, CLS_CBNZ, CLS_B};
        branch  = class_r inside {CLS_B, CLS_CBZ, CLS_CBNZ};
        // Taken-branch PC load depends on the live zero flag
        pcWrite = (class_r == CLS_B) || (class_r == CLS_CBZ && aluZero) ||
                  (class_r == CLS_CBNZ && !aluZero);
        retire  = class_r inside {CLS_B, CLS_CBZ, CLS_CBNZ, CLS_NOP};
      end
      ST_MEM: begin
        memRead  = (class_r == CLS_LDUR);
        memWrite = (class_r == CLS_STUR);
        retire   = memReady && (class_r == CLS_STUR);
      end
      ST_WB: begin
        regWrite = 1'b1;
        memToReg = (class_r == CLS_LDUR);
        retire   = 1'b1;
      end
      ST_TRAP: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`else
        illegal = 1'b0;
`endif
      end
      default: illegal = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller plus directed
// latency, counter-wrap, asynchronous-reset and illegal-opcode scenarios.
module tb_multicycle_controller;

  localparam int OPCODE_W = 11;
  localparam int ALUOP_W  = 4;
  localparam int CNT_W    = 2;
  localparam int N_INSTR  = 80;

  logic clk = 1'b0;
  logic rst_n, run, memReady, aluZero;
  logic [OPCODE_W-1:0] opCode;
  logic pcWrite, irWrite, reg2Loc, branch, memRead, memWrite, memToReg, aluSrc, regWrite;
  logic [ALUOP_W-1:0] aluOp;
  logic retire, illegal;
  logic [CNT_W-1:0] retireCount;
  logic [13:0] ctrl_all;

  multicycle_controller #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opCode(opCode), .memReady(memReady),
    .aluZero(aluZero), .pcWrite(pcWrite), .irWrite(irWrite), .reg2Loc(reg2Loc),
    .branch(branch), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .aluSrc(aluSrc), .regWrite(regWrite), .aluOp(aluOp), .retire(retire),
    .retireCount(retireCount), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign ctrl_all = {pcWrite, irWrite, reg2Loc, branch, memRead, memWrite,
                     memToReg, aluSrc, regWrite, retire, aluOp};

  typedef enum int {K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI, K_LDUR,
                    K_STUR, K_B, K_CBZ, K_CBNZ, K_BAD} kind_t;

  kind_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_cnt = 0;
  bit    mon_en = 1'b0;
  bit    active = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction-level behaviour from the ISA rules
  function automatic logic [10:0] make_opcode(input kind_t k);
    logic [10:0] r;
    r = 11'($urandom);
    case (k)
      K_B:     r = {6'b000101, r[4:0]};
      K_CBZ:   r = {8'b10110100, r[2:0]};
      K_CBNZ:  r = {8'b10110101, r[2:0]};
      K_ADDI:  r = {10'b1001000100, r[0]};
      K_SUBI:  r = {10'b1101000100, r[0]};
      K_AND:   r = 11'b10001010000;
      K_ADD:   r = 11'b10001011000;
      K_ORR:   r = 11'b10101010000;
      K_SUB:   r = 11'b11001011000;
      K_STUR:  r = 11'b11111000000;
      K_LDUR:  r = 11'b11111000010;
      default: r = r[0] ? 11'b00000000000 : 11'b11111111111;
    endcase
    return r;
  endfunction

  function automatic int ref_aluop(input kind_t k);
    case (k)
      K_ORR:                          return 1;
      K_ADD, K_ADDI, K_LDUR, K_STUR:  return 2;
      K_SUB, K_SUBI:                  return 6;
      K_CBZ:                          return 7;
      K_B:                            return 8;
      K_CBNZ:                         return 9;
      default:                        return 0;
    endcase
  endfunction

  function automatic bit is_br(input kind_t k);
    return (k == K_B) || (k == K_CBZ) || (k == K_CBNZ);
  endfunction

  function automatic bit ref_taken(input kind_t k, input bit z);
    return (k == K_B) || (k == K_CBZ && z) || (k == K_CBNZ && !z);
  endfunction

  function automatic bit ref_regwrite(input kind_t k);
    return k inside {K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI, K_LDUR};
  endfunction

  // Cycles from instruction load to retire, excluding memory-stage cycles
  function automatic int ref_base_lat(input kind_t k);
    return (is_br(k) || k == K_BAD || k == K_STUR) ? 3 : 4;
  endfunction

  int lat, memrd, memwr, hits, pc_extra;
  int aop;
  bit asrc, r2l, brs, rw, m2r, taken, bz;

  // Monitor: rebuild each instruction from observed strobes, check at retire
  always @(negedge clk) begin
    if (mon_en) begin
      kind_t k;
      chk("retire_count", retireCount, exp_cnt % (1 << CNT_W));
      chk("illegal_low", illegal, 0);
      if (irWrite) begin
        chk("fetch_strobes", {memRead, pcWrite, memReady}, 3'b111);
        active = 1'b1; lat = 1; memrd = 0; memwr = 0; hits = 0; pc_extra = 0;
        aop = 0; asrc = 0; r2l = 0; brs = 0; rw = 0; m2r = 0; taken = 0; bz = 0;
      end else if (active) begin
        lat++;
        aop |= int'(aluOp);
        asrc |= aluSrc; r2l |= reg2Loc; rw |= regWrite; m2r |= memToReg;
        memrd += int'(memRead); memwr += int'(memWrite);
        if ((memRead || memWrite) && memReady) hits++;
        if (branch) begin brs = 1'b1; bz = aluZero; taken = pcWrite; end
        else if (pcWrite) pc_extra++;
        if (retire) begin
          active = 1'b0;
          if (exp_q.size() == 0) begin
            chk("retire_unexpected", 1, 0);
          end else begin
            k = exp_q.pop_front();
            chk("aluop", aop, ref_aluop(k));
            chk("alusrc", asrc, k inside {K_ADDI, K_SUBI, K_LDUR, K_STUR});
            chk("reg2loc", r2l, k inside {K_STUR, K_CBZ, K_CBNZ, K_B});
            chk("branch", brs, is_br(k));
            chk("branch_taken", taken, ref_taken(k, bz));
            chk("pc_nonbranch", pc_extra, 0);
            chk("regwrite", rw, ref_regwrite(k));
            chk("memtoreg", m2r, k == K_LDUR);
            chk("ldur_memread", memrd > 0, k == K_LDUR);
            chk("stur_memwrite", memwr > 0, k == K_STUR);
            chk("mem_ready_hits", hits, (k == K_LDUR || k == K_STUR) ? 1 : 0);
            chk("latency", lat, ref_base_lat(k) + memrd + memwr);
          end
        end
      end else begin
        chk("spurious_retire", retire, 0);
      end
      if (retire) exp_cnt++;
    end
  end

  kind_t prog [N_INSTR];

  initial begin
    int idx, cyc, last_aop, t, prev_t, nret;
    bit fetch, seen;
    rst_n = 1'b0; run = 1'b0; memReady = 1'b0; aluZero = 1'b0; opCode = 11'b0;
    #12;
    chk("reset_ctrl", ctrl_all, 0);
    chk("reset_count", retireCount, 0);
    chk("reset_illegal", illegal, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_run", ctrl_all, 0);

    // Randomized program through an instruction memory model
    for (int i = 0; i < N_INSTR; i++) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      prog[i] = kind_t'($urandom_range(0, 10));
`else
      prog[i] = kind_t'($urandom_range(0, 11));
`endif
    end
    mon_en = 1'b1; idx = 0; cyc = 0; run = 1'b1;
    while ((idx < N_INSTR || exp_q.size() != 0 || active) && cyc < 5000) begin
      @(negedge clk); fetch = irWrite;
      @(posedge clk); #1; cyc++;
      if (fetch && idx < N_INSTR) begin
        opCode = make_opcode(prog[idx]);
        exp_q.push_back(prog[idx]);
        idx++;
      end
      run      = (idx < N_INSTR) && ($urandom_range(0, 7) != 0);
      memReady = ($urandom_range(0, 2) == 0);
      aluZero  = 1'($urandom_range(0, 1));
    end
    if (cyc >= 5000) chk("drain_timeout", 1, 0);
    @(negedge clk); mon_en = 1'b0;

    // Directed ADD stream: 4-cycle cadence, count wraps at 2 bits
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("rst_count_clear", retireCount, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    opCode = 11'b10001011000; memReady = 1'b1; aluZero = 1'b0; run = 1'b1;
    nret = 0; prev_t = 0; last_aop = -1;
    for (t = 1; t < 60 && nret < 5; t++) begin
      @(negedge clk);
      if (aluOp != 4'b0000) last_aop = int'(aluOp);
      if (retire) begin
        nret++;
        chk("add_regwrite", regWrite, 1);
        chk("add_aluop", last_aop, 2);
        chk("add_count_before", retireCount, (nret - 1) % 4);
        if (nret > 1) chk("add_latency", t - prev_t, 4);
        prev_t = t;
        if (nret == 5) opCode = 11'b11111000000;
      end
    end
    chk("add_retires", nret, 5);
    @(negedge clk);
    chk("add_count_wrapped", retireCount, 1);

    // STUR stalled in MEM, then asynchronous reset mid-access
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); seen = irWrite;
    end
    chk("stur_fetch_seen", seen, 1);
    @(posedge clk); #1 memReady = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); seen = memWrite;
    end
    chk("stur_memwrite_seen", seen, 1);
    repeat (2) @(negedge clk);
    chk("stur_held", {memWrite, retire}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_memwrite_drop", memWrite, 0);
    chk("rst_ctrl_zero", ctrl_all, 0);
    chk("rst_count_zero", retireCount, 0);
    run = 1'b0; memReady = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {ctrl_all, illegal}, 0);

    // Unknown opcode: trapped or executed as a counted NOP
    opCode = 11'b00000000000; run = 1'b1;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); seen = illegal;
    end
    chk("trap_entered", seen, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("trap_hold", {illegal, ctrl_all}, 15'h4000);
    end
    chk("trap_count", retireCount, 0);
`else
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); seen = retire;
      if (retire) chk("nop_retire_quiet", {regWrite, memWrite, branch, pcWrite}, 0);
    end
    chk("nop_retired", seen, 1);
    run = 1'b0;
    @(negedge clk);
    chk("nop_counted", retireCount, 1);
    chk("nop_illegal_low", illegal, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
